alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the combinational execute-stage ALU.
- Registers operands and result, and adds status flags and SLT.
- Adds arithmetic vs logical shift distinction with saturating shift amounts.
- Adds a multi-cycle iterative signed multiply (low half).
- Sits between operand fetch/decode and writeback; valid/ready on both sides lets a stalled consumer back-pressure the producer.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_iter.sv | 71 +++++++
 rtl/alu_pipe.sv | 168 ++++++++++++++++
 tb/tb_alu_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute-stage ALU: op codes, FSM states, flag bundle.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_MULT = 6'b011000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low LENGTH bits of a*b, one bit per cycle.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LENGTH-1:0] a,
  input  logic [LENGTH-1:0] b,
  output logic              done,
  output logic [LENGTH-1:0] product
);

  localparam int CW = $clog2(LENGTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  logic [LENGTH-1:0] mcand_q, mcand_d;
  logic [LENGTH-1:0] mplier_q, mplier_d;
  logic [LENGTH-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [LENGTH-1:0] acc_step;

  // Low half of a two's-complement product is sign-agnostic, so a plain unsigned shift-add suffices.
  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // The last iteration's sum is handed out directly so the top can register it on the same edge.
  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_step;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU: registered result and flags, saturating shifts, SLT and an
// iterative multiply, with valid/ready back-pressure on both sides.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int LENGTH = 8,
  localparam int SHW    = $clog2(LENGTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] busA,
  input  logic [LENGTH-1:0] busB,
  input  logic [5:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] salida,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              op_err
);

  localparam int MSB = LENGTH - 1;
  localparam logic [LENGTH-1:0] LEN_V = LENGTH'(LENGTH);

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [LENGTH-1:0] salida_q, salida_d;
  flags_t            flags_q, flags_d;
  logic              op_err_q, op_err_d;

  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [LENGTH-1:0] mul_product;

  logic [LENGTH:0]   add_full;
  logic [LENGTH:0]   sub_full;
  logic [SHW-1:0]    shamt;
  logic              shift_sat;
  logic [LENGTH-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic              alu_err;
  flags_t            alu_flags;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // SUB is formed as A + ~B + 1 so its carry out reads directly as "no borrow".
  always_comb begin
    add_full  = {1'b0, busA} + {1'b0, busB};
    sub_full  = {1'b0, busA} + {1'b0, ~busB} + {{LENGTH{1'b0}}, 1'b1};
    shift_sat = (busB >= LEN_V);
    shamt     = busB[SHW-1:0];
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_full[LENGTH-1:0];
        alu_c   = add_full[LENGTH];
        alu_v   = (busA[MSB] == busB[MSB]) && (alu_res[MSB] != busA[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_full[LENGTH-1:0];
        alu_c   = sub_full[LENGTH];
        alu_v   = (busA[MSB] != busB[MSB]) && (alu_res[MSB] != busA[MSB]);
      end
      OP_AND:  alu_res = busA & busB;
      OP_OR:   alu_res = busA | busB;
      OP_XOR:  alu_res = busA ^ busB;
      OP_NOR:  alu_res = ~(busA | busB);
      OP_SLL:  alu_res = shift_sat ? '0 : (busA << shamt);
      OP_SRL:  alu_res = shift_sat ? '0 : (busA >> shamt);
      OP_SRA:  alu_res = shift_sat ? {LENGTH{busA[MSB]}} : ($signed(busA) >>> shamt);
      OP_SLT:  alu_res = {{(LENGTH-1){1'b0}}, ($signed(busA) < $signed(busB))};
      OP_MULT: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
    alu_flags.z = (alu_res == '0);
    alu_flags.n = alu_res[MSB];
    alu_flags.c = alu_c;
    alu_flags.v = alu_v;
  end

  // A single-cycle accept on a handshake edge overwrites the departing result, keeping out_valid high.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    salida_d    = salida_q;
    flags_d     = flags_q;
    op_err_d    = op_err_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (op == OP_MULT) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            salida_d    = alu_res;
            flags_d     = alu_flags;
            op_err_d    = alu_err;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          salida_d    = mul_product;
          flags_d.z   = (mul_product == '0);
          flags_d.n   = mul_product[MSB];
          flags_d.c   = 1'b0;
          flags_d.v   = 1'b0;
          op_err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      salida_q    <= '0;
      flags_q     <= '0;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      salida_q    <= salida_d;
      flags_q     <= flags_d;
      op_err_q    <= op_err_d;
    end
  end

  alu_mul_iter #(
    .LENGTH (LENGTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (busA),
    .b       (busB),
    .done    (mul_done),
    .product (mul_product)
  );

  assign out_valid = out_valid_q;
  assign salida    = salida_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe, checked against an arithmetic reference model.
module tb_alu_pipe;

  localparam int L = 8;

  localparam logic [5:0] T_ADD  = 6'b100000;
  localparam logic [5:0] T_SUB  = 6'b100010;
  localparam logic [5:0] T_AND  = 6'b100100;
  localparam logic [5:0] T_OR   = 6'b100101;
  localparam logic [5:0] T_XOR  = 6'b100110;
  localparam logic [5:0] T_NOR  = 6'b100111;
  localparam logic [5:0] T_SLL  = 6'b000000;
  localparam logic [5:0] T_SRL  = 6'b000010;
  localparam logic [5:0] T_SRA  = 6'b000011;
  localparam logic [5:0] T_SLT  = 6'b101010;
  localparam logic [5:0] T_MULT = 6'b011000;
  localparam logic [5:0] T_BAD  = 6'b111111;

  typedef struct packed {
    logic [L-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         err;
  } exp_t;

  typedef struct {
    logic [5:0]   o;
    logic [L-1:0] a;
    logic [L-1:0] b;
    logic [L-1:0] res;
    logic [4:0]   fl;
  } shift_case_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [L-1:0] busA;
  logic [L-1:0] busB;
  logic [5:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [L-1:0] salida;
  logic         flag_z, flag_n, flag_c, flag_v, op_err;

  int compared   = 0;
  int mismatched = 0;

  alu_pipe #(.LENGTH(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busA      (busA),
    .busB      (busB),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .salida    (salida),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  // Result computed with plain integer arithmetic on signed/unsigned views of the operands.
  function automatic exp_t refModel(input logic [5:0] o, input logic [L-1:0] a, input logic [L-1:0] b);
    exp_t e;
    int ua, ub, sa, sb, r, maxs, mins;
    ua   = a;
    ub   = b;
    sa   = $signed(a);
    sb   = $signed(b);
    maxs = (1 << (L - 1)) - 1;
    mins = -(1 << (L - 1));
    e    = '0;
    r    = 0;
    case (o)
      T_ADD: begin
        r   = ua + ub;
        e.c = (r >= (1 << L));
        e.v = ((sa + sb) > maxs) || ((sa + sb) < mins);
      end
      T_SUB: begin
        r   = ua - ub;
        e.c = (ua >= ub);
        e.v = ((sa - sb) > maxs) || ((sa - sb) < mins);
      end
      T_AND:  r = ua & ub;
      T_OR:   r = ua | ub;
      T_XOR:  r = ua ^ ub;
      T_NOR:  r = ~(ua | ub);
      T_SLL:  r = (ub >= L) ? 0 : (ua << ub);
      T_SRL:  r = (ub >= L) ? 0 : (ua >> ub);
      T_SRA:  r = (ub >= L) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
      T_SLT:  r = (sa < sb) ? 1 : 0;
      T_MULT: r = sa * sb;
      default: begin
        r     = 0;
        e.err = 1'b1;
      end
    endcase
    e.res = r[L-1:0];
    e.z   = (e.res == '0);
    e.n   = e.res[L-1];
    return e;
  endfunction

  function automatic logic [31:0] obsVec();
    return 32'({out_valid, salida, flag_z, flag_n, flag_c, flag_v, op_err});
  endfunction

  function automatic logic [31:0] expVec(input exp_t e);
    return 32'({1'b1, e});
  endfunction

  function automatic logic [31:0] dirVec(input logic [L-1:0] res, input logic [4:0] fl);
    return 32'({1'b1, res, fl});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one operation, waits (bounded) for in_ready, and returns just after the accept edge.
  task automatic applyStimulus(input logic [5:0] o, input logic [L-1:0] a, input logic [L-1:0] b);
    int waitc;
    waitc    = 0;
    op       = o;
    busA     = a;
    busB     = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waitc < 40) begin
      tick();
      waitc++;
    end
    checkOutput("accept within bound", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  shift_case_t shifts[4];

  initial begin
    int          lat;
    int          stall;
    logic [5:0]  o;
    logic [L-1:0] a, b;
    logic [31:0] held;
    exp_t        e;
    logic [5:0]  ops[12];

    ops = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR, T_SLL, T_SRL, T_SRA, T_SLT, T_MULT, T_BAD};
    shifts[0] = '{T_SRA, 8'h80, 8'd9, 8'hFF, 5'b01000};
    shifts[1] = '{T_SRL, 8'h80, 8'd9, 8'h00, 5'b10000};
    shifts[2] = '{T_SLL, 8'h01, 8'd7, 8'h80, 5'b01000};
    shifts[3] = '{T_SRA, 8'h90, 8'd0, 8'h90, 5'b01000};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    busA      = '0;
    busB      = '0;
    op        = '0;
    tick();
    tick();
    checkOutput("reset outputs", obsVec(), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("ready after reset", 32'(in_ready), 32'd1);

    applyStimulus(T_ADD, 8'h7F, 8'h01);
    checkOutput("add 7F+01", obsVec(), dirVec(8'h80, 5'b01010));
    tick();
    checkOutput("add valid one cycle", 32'(out_valid), 32'd0);

    op = T_SUB; busA = 8'h05; busB = 8'h05; in_valid = 1'b1;
    #1;
    checkOutput("sub ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("sub 05-05", obsVec(), dirVec(8'h00, 5'b10100));
    op = T_SLT; busA = 8'hFE; busB = 8'h01;
    #1;
    checkOutput("slt ready no bubble", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("slt FE<01", obsVec(), dirVec(8'h01, 5'b00000));
    tick();
    checkOutput("slt consumed", 32'(out_valid), 32'd0);

    applyStimulus(T_MULT, 8'hFD, 8'h07);
    for (int i = 0; i < L; i++) begin
      checkOutput($sformatf("mul busy cycle %0d", i), 32'({in_ready, out_valid}), 32'd0);
      tick();
    end
    checkOutput("mul FD*07", obsVec(), dirVec(8'hEB, 5'b01000));
    tick();
    checkOutput("mul consumed", 32'(out_valid), 32'd0);
    applyStimulus(T_MULT, 8'h10, 8'h10);
    waitValid(lat);
    checkOutput("mul latency", 32'(lat), 32'(L));
    checkOutput("mul 10*10", obsVec(), dirVec(8'h00, 5'b10000));

    foreach (shifts[i]) begin
      applyStimulus(shifts[i].o, shifts[i].a, shifts[i].b);
      checkOutput($sformatf("shift case %0d", i), obsVec(), dirVec(shifts[i].res, shifts[i].fl));
    end
    tick();

    out_ready = 1'b0;
    applyStimulus(T_BAD, 8'h12, 8'h34);
    checkOutput("bad op", obsVec(), dirVec(8'h00, 5'b10001));
    op = T_ADD; busA = 8'h01; busB = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("hold ready %0d", i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("hold stable %0d", i), obsVec(), dirVec(8'h00, 5'b10001));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("release ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("released valid", 32'(out_valid), 32'd0);
    checkOutput("released ready", 32'(in_ready), 32'd1);

    applyStimulus(T_MULT, 8'h03, 8'h05);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("reset during mul", obsVec(), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("ready after abort", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("no stale result %0d", i), 32'(out_valid), 32'd0);
      tick();
    end

    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(0, 11)];
      a = L'($urandom);
      b = L'($urandom);
      if ((o == T_SLL || o == T_SRL || o == T_SRA) && $urandom_range(0, 2) != 0) begin
        b = L'($urandom_range(0, 10));
      end
      e = refModel(o, a, b);
      out_ready = 1'b1;
      applyStimulus(o, a, b);
      waitValid(lat);
      checkOutput($sformatf("rand %0d latency op %b", n, o), 32'(lat), (o == T_MULT) ? 32'(L) : 32'd0);
      checkOutput($sformatf("rand %0d op %b a %h b %h", n, o, a, b), obsVec(), expVec(e));
      stall = $urandom_range(0, 2);
      if (stall > 0) begin
        out_ready = 1'b0;
        held      = obsVec();
        repeat (stall) begin
          tick();
          checkOutput($sformatf("rand %0d stall stable", n), obsVec(), expVec(e));
          checkOutput($sformatf("rand %0d stall ready", n), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        held      = '0;
      end
    end
    tick();
    checkOutput("final drain", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
